// File: rtl/spi_engine.sv
// spi_engine: single-byte full-duplex SPI master, MSB first, modes 0 and 3.
//
// A request on start_i (taken only while idle) latches the byte, the clock
// polarity, the select pattern and the keep-select flag. The engine then
// runs SETUP, PHA/PHB for bits 7..0 and HOLD. Each of these states lasts
// DIV clk_i cycles. On leaving HOLD it presents the received byte on rxd_o
// and pulses done_o for one cycle.
//
// Parameters
//   DIV        SCK half-period in clk_i cycles, 1..255
// Ports
//   clk_i      system clock, rising edge
//   rst_i      synchronous reset, active high
//   start_i    transfer request, accepted when busy_o=0
//   txd_i      byte to send (sampled on accept)
//   cpol_i     0: mode 0 (SCK idles low), 1: mode 3 (idles high)
//   ssel_i     active-low select pattern driven on nss_o during transfer
//   keep_i     1: leave nss_o asserted after the transfer
//   release_i  idle-only pulse that deasserts nss_o
//   miso_i     serial data in
//   sck_o      serial clock (registered)
//   mosi_o     serial data out (registered)
//   nss_o      active-low chip selects (registered)
//   busy_o     transfer in progress
//   done_o     one-cycle completion strobe
//   rxd_o      last received byte, held until the next completion
module spi_engine #(
    parameter int unsigned DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [7:0] txd_i,
    input  logic       cpol_i,
    input  logic [1:0] ssel_i,
    input  logic       keep_i,
    input  logic       release_i,
    input  logic       miso_i,
    output logic       sck_o,
    output logic       mosi_o,
    output logic [1:0] nss_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rxd_o
);

    localparam logic [7:0] RELOAD = 8'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PHA,
        S_PHB,
        S_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rxd_q, rxd_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic [1:0] nss_q, nss_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cpol_q, cpol_d;
    logic       keep_q, keep_d;
    logic [1:0] ssel_q, ssel_d;
    logic       miso_q;
    logic       last;

    // Phase counter expires on the last cycle of the current state.
    assign last = (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q - 8'd1;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        nss_d   = nss_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cpol_d  = cpol_q;
        keep_d  = keep_q;
        ssel_d  = ssel_q;

        unique case (state_q)
            S_IDLE: begin
                sck_d = cpol_q;
                // START takes priority over RELEASE in the same cycle.
                if (start_i) begin
                    tx_d    = txd_i;
                    cpol_d  = cpol_i;
                    keep_d  = keep_i;
                    ssel_d  = ssel_i;
                    nss_d   = ssel_i;
                    mosi_d  = txd_i[7];
                    sck_d   = cpol_i;
                    busy_d  = 1'b1;
                    cnt_d   = RELOAD;
                    state_d = S_SETUP;
                end else if (release_i) begin
                    nss_d = 2'b11;
                end
            end
            S_SETUP: begin
                if (last) begin
                    sck_d   = 1'b0;
                    bit_d   = 3'd7;
                    cnt_d   = RELOAD;
                    state_d = S_PHA;
                end
            end
            S_PHA: begin
                if (last) begin
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[6:0], miso_q};
                    cnt_d   = RELOAD;
                    state_d = S_PHB;
                end
            end
            S_PHB: begin
                if (last) begin
                    cnt_d = RELOAD;
                    if (bit_q != 3'd0) begin
                        // tx_q[7] is always the bit on the wire; shift the next one up.
                        sck_d   = 1'b0;
                        bit_d   = bit_q - 3'd1;
                        tx_d    = {tx_q[6:0], 1'b0};
                        mosi_d  = tx_q[6];
                        state_d = S_PHA;
                    end else begin
                        sck_d   = cpol_q;
                        mosi_d  = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (last) begin
                    rxd_d   = rx_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    nss_d   = keep_q ? ssel_q : 2'b11;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            rxd_q   <= 8'h00;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            nss_q   <= 2'b11;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cpol_q  <= 1'b0;
            keep_q  <= 1'b0;
            ssel_q  <= 2'b11;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            nss_q   <= nss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cpol_q  <= cpol_d;
            keep_q  <= keep_d;
            ssel_q  <= ssel_d;
            // Single sampling flop; the shift into rx_q uses this registered copy.
            miso_q  <= miso_i;
        end
    end

    assign sck_o  = sck_q;
    assign mosi_o = mosi_q;
    assign nss_o  = nss_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign rxd_o  = rxd_q;

endmodule

// File: tb/tb_spi_engine.sv
// Testbench for spi_engine: two instances (DIV=2 and DIV=1) driven by
// directed and random transfers. A cycle-level reference model derives
// every output from the transfer parameters and the cycle count since
// acceptance; received bytes go through a scoreboard queue that is popped
// whenever an instance raises its DONE strobe.
module tb_spi_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s   [2];
    logic       start_s [2];
    logic       cpol_s  [2];
    logic       keep_s  [2];
    logic       rel_s   [2];
    logic       miso_s  [2];
    logic [7:0] txd_s   [2];
    logic [1:0] ssel_s  [2];

    wire        sck_w  [2];
    wire        mosi_w [2];
    wire        busy_w [2];
    wire        done_w [2];
    wire  [1:0] nss_w  [2];
    wire  [7:0] rxd_w  [2];

    spi_engine #(.DIV(2)) u_div2 (
        .clk_i(clk), .rst_i(rst_s[0]), .start_i(start_s[0]), .txd_i(txd_s[0]),
        .cpol_i(cpol_s[0]), .ssel_i(ssel_s[0]), .keep_i(keep_s[0]),
        .release_i(rel_s[0]), .miso_i(miso_s[0]), .sck_o(sck_w[0]),
        .mosi_o(mosi_w[0]), .nss_o(nss_w[0]), .busy_o(busy_w[0]),
        .done_o(done_w[0]), .rxd_o(rxd_w[0])
    );

    spi_engine #(.DIV(1)) u_div1 (
        .clk_i(clk), .rst_i(rst_s[1]), .start_i(start_s[1]), .txd_i(txd_s[1]),
        .cpol_i(cpol_s[1]), .ssel_i(ssel_s[1]), .keep_i(keep_s[1]),
        .release_i(rel_s[1]), .miso_i(miso_s[1]), .sck_o(sck_w[1]),
        .mosi_o(mosi_w[1]), .nss_o(nss_w[1]), .busy_o(busy_w[1]),
        .done_o(done_w[1]), .rxd_o(rxd_w[1])
    );

    int total = 0;
    int bad   = 0;
    logic [7:0] sbq0[$];
    logic [7:0] sbq1[$];

    function automatic int div_of(int d);
        return (d == 0) ? 2 : 1;
    endfunction

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s u%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- reference model (updated at each rising edge) -------
    bit         m_armed [2];
    bit         m_busy  [2];
    int         m_c     [2];
    logic [7:0] m_txd   [2];
    logic [7:0] m_rxd   [2];
    logic       m_cpol  [2];
    logic       m_keep  [2];
    logic       m_done  [2];
    logic [1:0] m_ssel  [2];
    logic [1:0] m_nss   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_armed[d] = 0; m_busy[d] = 0; m_c[d] = 0; m_done[d] = 1'b0;
            m_txd[d] = 8'h00; m_rxd[d] = 8'h00; m_cpol[d] = 1'b0;
            m_keep[d] = 1'b0; m_ssel[d] = 2'b11; m_nss[d] = 2'b11;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                m_done[d] = 1'b0;
                if (rst_s[d]) begin
                    m_armed[d] = 1; m_busy[d] = 0; m_cpol[d] = 1'b0;
                    m_keep[d] = 1'b0; m_nss[d] = 2'b11; m_rxd[d] = 8'h00;
                    if (d == 0) sbq0.delete(); else sbq1.delete();
                end else if (m_busy[d]) begin
                    m_c[d]++;
                    if (m_c[d] == 18 * div_of(d)) begin
                        m_busy[d] = 0;
                        m_done[d] = 1'b1;
                        m_nss[d]  = m_keep[d] ? m_ssel[d] : 2'b11;
                    end
                end else if (start_s[d]) begin
                    m_busy[d] = 1; m_c[d] = 0;
                    m_txd[d] = txd_s[d]; m_cpol[d] = cpol_s[d];
                    m_ssel[d] = ssel_s[d]; m_keep[d] = keep_s[d];
                    m_nss[d] = ssel_s[d];
                end else if (rel_s[d]) begin
                    m_nss[d] = 2'b11;
                end
            end
        end
    end

    // ---------------- monitor (samples on falling edge) ---------------------
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (m_armed[d]) begin
                    logic       esck, emosi;
                    logic [7:0] t, got;
                    int         p;
                    t = m_txd[d]; esck = m_cpol[d]; emosi = 1'b1;
                    if (m_busy[d]) begin
                        // phase 0 = SETUP, 1..16 = PHA/PHB pairs, 17 = HOLD
                        p = m_c[d] / div_of(d);
                        if (p == 0) begin
                            emosi = t[7];
                        end else if (p <= 16) begin
                            esck  = ((p - 1) % 2 == 1);
                            emosi = t[7 - (p - 1) / 2];
                        end
                    end
                    chk("sck",  d, 32'(sck_w[d]),  32'(esck));
                    chk("mosi", d, 32'(mosi_w[d]), 32'(emosi));
                    chk("nss",  d, 32'(nss_w[d]),  32'(m_nss[d]));
                    chk("busy", d, 32'(busy_w[d]), 32'(m_busy[d]));
                    chk("done", d, 32'(done_w[d]), 32'(m_done[d]));
                    if (done_w[d] === 1'b1) begin
                        p = (d == 0) ? sbq0.size() : sbq1.size();
                        chk("sb_nonempty", d, 32'(p > 0), 32'd1);
                        if (p > 0) begin
                            got = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
                            chk("rxd_sb", d, 32'(rxd_w[d]), 32'(got));
                            m_rxd[d] = got;
                        end
                    end else begin
                        chk("rxd_hold", d, 32'(rxd_w[d]), 32'(m_rxd[d]));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int d, int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_release(int d);
        rel_s[d] = 1'b1;
        step();
        rel_s[d] = 1'b0;
    endtask

    // One transfer. mb is the byte the MISO model presents: bit k is driven
    // only in the cycle that the sampling flop captures just before the k-th
    // SCK rising edge, with random junk elsewhere. loopb ties MISO to MOSI.
    task automatic xfer(int d, logic [7:0] t, logic cp, logic [1:0] ss, logic kp,
                        logic [7:0] mb, bit loopb, logic relw, int busy_at, int rst_at);
        int dv;
        dv = div_of(d);
        start_s[d] = 1'b1; txd_s[d] = t; cpol_s[d] = cp; ssel_s[d] = ss;
        keep_s[d] = kp; rel_s[d] = relw;
        step();
        start_s[d] = 1'b0; rel_s[d] = 1'b0;
        txd_s[d] = 8'($urandom); cpol_s[d] = 1'($urandom);
        ssel_s[d] = 2'($urandom); keep_s[d] = 1'($urandom);
        if (d == 0) sbq0.push_back(loopb ? t : mb); else sbq1.push_back(loopb ? t : mb);
        for (int c = 0; c < 18 * dv; c++) begin
            miso_s[d] = 1'($urandom);
            if (loopb) miso_s[d] = mosi_w[d];
            else for (int k = 0; k < 8; k++) if (c == 2 * dv * (8 - k) - 2) miso_s[d] = mb[k];
            start_s[d] = (c == busy_at);
            if (c == busy_at) txd_s[d] = 8'h00;
            if (c == rst_at) begin
                start_s[d] = 1'b0;
                rst_s[d] = 1'b1;
                step();
                rst_s[d] = 1'b0;
                return;
            end
            step();
        end
        start_s[d] = 1'b0;
    endtask

    task automatic random_run(int d, int n);
        int gap;
        for (int i = 0; i < n; i++) begin
            xfer(d, 8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 8'($urandom), (d == 0) && ($urandom_range(0, 2) == 0), 1'($urandom),
                 ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18 * div_of(d) - 1)) : -1,
                 -1);
            gap = int'($urandom_range(0, 3));
            if (gap > 0 && $urandom_range(0, 1) == 1) begin
                pulse_release(d);
                gap--;
            end
            idle(d, gap);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_s[d] = 1'b1; start_s[d] = 1'b0; cpol_s[d] = 1'b0; keep_s[d] = 1'b0;
            rel_s[d] = 1'b0; miso_s[d] = 1'b0; txd_s[d] = 8'h00; ssel_s[d] = 2'b11;
        end
        step(); step(); step();
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        idle(0, 2);

        // DIV=2: loopback mode 0
        xfer(0, 8'hA5, 1'b0, 2'b10, 1'b0, 8'h00, 1, 1'b0, -1, -1);
        idle(0, 3);
        // mode 3 with MISO pattern
        xfer(0, 8'hFF, 1'b1, 2'b10, 1'b0, 8'h3C, 0, 1'b0, -1, -1);
        idle(0, 2);
        // KEEP, back-to-back, then RELEASE
        xfer(0, 8'($urandom), 1'b0, 2'b01, 1'b1, 8'($urandom), 0, 1'b0, -1, -1);
        xfer(0, 8'($urandom), 1'b0, 2'b01, 1'b1, 8'($urandom), 0, 1'b0, -1, -1);
        idle(0, 2);
        pulse_release(0);
        idle(0, 2);
        // START while busy
        xfer(0, 8'($urandom), 1'b0, 2'b10, 1'b0, 8'($urandom), 0, 1'b0, 10, -1);
        idle(0, 2);
        // reset during PHB(4), then a normal transfer
        xfer(0, 8'($urandom), 1'b1, 2'b01, 1'b1, 8'($urandom), 0, 1'b0, -1, 16);
        idle(0, 2);
        xfer(0, 8'h5A, 1'b0, 2'b10, 1'b0, 8'hC3, 0, 1'b0, -1, -1);
        idle(0, 1);
        random_run(0, 6);
        idle(0, 2);

        // DIV=1: KEEP transfer, then START+RELEASE together in the DONE cycle
        xfer(1, 8'($urandom), 1'b0, 2'b10, 1'b1, 8'($urandom), 0, 1'b0, -1, -1);
        xfer(1, 8'($urandom), 1'b1, 2'b01, 1'b0, 8'($urandom), 0, 1'b1, -1, -1);
        idle(1, 2);
        random_run(1, 8);
        idle(1, 3);

        chk("sbq_empty", 0, 32'(sbq0.size()), 32'd0);
        chk("sbq_empty", 1, 32'(sbq1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
